// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller around an external dual-port RAM.
// Port A writes at wr_ptr; port B reads ahead so the head entry is always presented on m_data.
module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);

    localparam logic [ADDR_WIDTH:0]   DEPTH   = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_TWO = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  m_valid_next;
    logic                  push;
    logic                  pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign s_ready = !full && !flush;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    assign ram_we_a   = push;
    assign ram_addr_a = wr_ptr;
    assign ram_din_a  = s_data;
    assign ram_we_b   = 1'b0;

    // Read one ahead on a pop so the next head arrives at the same edge; hold on stall.
    assign ram_addr_b = pop ? rd_ptr + PTR_ONE : rd_ptr;
    assign m_data     = ram_dout_b;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // Pre-edge count excludes a write landing now: the RAM returns old data on that address.
    assign m_valid_next = pop ? (count >= CNT_TWO) : (count >= CNT_ONE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            m_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            m_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count   <= count_next;
            m_valid <= m_valid_next;
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural RAM, directed stimulus, queue scoreboard
// popped by a negedge monitor that also tracks the expected flags and RAM addresses.
module tb_dpram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_din_a;
    logic          ram_we_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_dout_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .count(count), .full(full), .empty(empty),
        .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
        .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_dout_b(ram_dout_b)
    );

    // RAM model: registered read, old data on same-address read-during-write, contents never reset.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected state: scoreboard queue plus pointers, count and m_valid.
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] e_wr, e_rd;
    logic [AW:0]   e_count;
    logic          e_valid;

    always begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            #1;
            check("rst_m_valid", 32'(m_valid), 0);
            check("rst_count", 32'(count), 0);
            check("rst_full", 32'(full), 0);
            check("rst_empty", 32'(empty), 1);
            check("rst_s_ready", 32'(s_ready), 1);
            check("rst_we_a", 32'(ram_we_a), 0);
            check("rst_we_b", 32'(ram_we_b), 0);
            check("rst_addr_a", 32'(ram_addr_a), 0);
            check("rst_addr_b", 32'(ram_addr_b), 0);
            exp_q.delete();
            e_wr = '0; e_rd = '0; e_count = '0; e_valid = 1'b0;
        end else begin
            logic e_ready, e_push, e_pop;
            logic [AW-1:0] e_addr_b;
            e_ready  = (e_count != (AW+1)'(DEPTH)) && !flush;
            e_push   = s_valid && e_ready;
            e_pop    = e_valid && m_ready;
            e_addr_b = e_pop ? e_rd + 4'd1 : e_rd;
            check("s_ready", 32'(s_ready), 32'(e_ready));
            check("m_valid", 32'(m_valid), 32'(e_valid));
            check("count", 32'(count), 32'(e_count));
            check("full", 32'(full), 32'(e_count == (AW+1)'(DEPTH)));
            check("empty", 32'(empty), 32'(e_count == 0));
            check("we_a", 32'(ram_we_a), 32'(e_push));
            check("we_b", 32'(ram_we_b), 0);
            check("addr_a", 32'(ram_addr_a), 32'(e_wr));
            check("addr_b", 32'(ram_addr_b), 32'(e_addr_b));
            if (e_push) check("din_a", 32'(ram_din_a), 32'(s_data));
            if (e_valid) begin
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else check("m_data", 32'(m_data), 32'(exp_q[0]));
            end
            if (flush) begin
                exp_q.delete();
                e_wr = '0; e_rd = '0; e_count = '0; e_valid = 1'b0;
            end else begin
                e_valid = e_pop ? (e_count >= 2) : (e_count >= 1);
                if (e_pop) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    e_rd = e_rd + 4'd1;
                    e_count = e_count - 1'b1;
                end
                if (e_push) begin
                    exp_q.push_back(s_data);
                    e_wr = e_wr + 4'd1;
                    e_count = e_count + 1'b1;
                end
            end
        end
    end

    task automatic drive(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic mr);
        for (int i = 0; i < n; i++) drive(1'b0, '0, mr, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single entry: push A5, visible after the following edge, then pop.
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Fill to full, attempt overflow, pop-while-full then push, drain.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        drive(1'b1, 8'hEF, 1'b1, 1'b0);
        idle(20, 1'b1);

        // Streaming across pointer wrap.
        for (int i = 0; i < 40; i++) drive(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
        idle(5, 1'b1);

        // Stall with three entries.
        for (int i = 0; i < 3; i++) drive(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        idle(5, 1'b0);
        idle(5, 1'b1);

        // Bubble: count == 1, push and pop together.
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        idle(1, 1'b0);
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Flush with five entries and a concurrent push request.
        for (int i = 0; i < 5; i++) drive(1'b1, DW'(8'h70 + i), 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        idle(2, 1'b0);
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Asynchronous reset between edges mid-stream.
        for (int i = 0; i < 6; i++) drive(1'b1, DW'(8'h90 + i), i > 2, 1'b0);
        @(negedge clk);
        #2;
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Synchronous FIFO controller that wraps the team's dual-port RAM: RAM port A is the write port and port B is the read port. It exposes a valid/ready push interface upstream and a valid/ready pop interface downstream. The RAM instance sits outside this block and connects through the `ram_*` ports. Sustained throughput is one push and one pop per clock.

## Interface
- `DATA_WIDTH`, default 8: entry width. Must match the RAM.
- `ADDR_WIDTH`, default 4: RAM address width. Depth `DEPTH` = 2^ADDR_WIDTH.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `flush`  in  1: synchronous clear; discards all contents.
- `s_valid`  in  1: push request.
- `s_data`  in  DATA_WIDTH: push data.
- `s_ready`  out  1: push accepted when high together with `s_valid`.
- `m_valid`  out  1: `m_data` holds the head entry.
- `m_data`  out  DATA_WIDTH: head entry, wired directly from `ram_dout_b`.
- `m_ready`  in  1: pop when high together with `m_valid`.
- `count`  out  ADDR_WIDTH+1: number of entries written to RAM and not yet popped.
- `full`  out  1: `count == DEPTH`.
- `empty`  out  1: `count == 0`.
- `ram_we_a`  out  1: RAM port A write enable.
- `ram_addr_a`  out  ADDR_WIDTH: port A address.
- `ram_din_a`  out  DATA_WIDTH: port A write data.
- `ram_we_b`  out  1: port B write enable; tied to 0.
- `ram_addr_b`  out  ADDR_WIDTH: port B read address.
- `ram_dout_b`  in  DATA_WIDTH: port B read data (registered in the RAM, one-cycle latency).

## Operation
- **State registers:** `wr_ptr`, `rd_ptr` (ADDR_WIDTH bits each, wrap modulo DEPTH), `count`, `m_valid`.
- **Handshake events:**
  - `push = s_valid & s_ready`.
  - `pop = m_valid & m_ready`.
- **Write side:**
  - `s_ready = !full & !flush`. There is no bypass when full, even if a pop occurs in the same cycle.
  - `ram_we_a = push`, `ram_addr_a = wr_ptr`, `ram_din_a = s_data`. All three are combinational.
  - `wr_ptr` increments on a push.
- **Read side:**
  - `ram_addr_b` is combinational: `rd_ptr + 1` when `pop`, otherwise `rd_ptr`.
  - This prefetches the next entry at the same edge as the pop.
  - `rd_ptr` increments on a pop.
- **Count:** `count_next = count + push - pop`. Never exceeds DEPTH and never goes negative, because the handshakes prevent it.
- **m_valid update:** `m_valid_next = pop ? (count >= 2) : (count >= 1)`. `count` here is the pre-edge value, so it excludes a write landing at the same edge.
  - Rationale: the RAM returns old data on a same-address read-during-write. An entry becomes readable only at the edge after the one that wrote it.
- **Flush:** on the edge where `flush` is high, `wr_ptr`, `rd_ptr`, `count` and `m_valid` are cleared to 0.
  - `flush` overrides any push or pop in that cycle.
  - `s_ready` is 0 during the flush cycle, so no RAM write occurs.
- **m_data:** undefined whenever `m_valid` is 0. The bench must not check it then.
- **Stall hold:** while `m_valid & !m_ready`, `ram_addr_b` is held at `rd_ptr`, so `m_data` stays stable.

## Timing
- **Reset values (async on `rst_n` low):**
  - `m_valid` = 0, `count` = 0.
  - `full` = 0, `empty` = 1, `s_ready` = 1.
  - `wr_ptr` = `rd_ptr` = 0, so `ram_addr_a` = `ram_addr_b` = 0 and `ram_we_a` = `ram_we_b` = 0.
  - Reset mid-operation discards all contents. RAM contents are not cleared.
- **Latency:** push into an empty FIFO at edge E results in `m_valid` high after edge E+1.
- **Throughput:** with `count >= 2`, continuous pops give back-to-back `m_valid` with no bubble.
- **Bubble case:** when `count == 1` and a push and a pop occur in the same cycle, `m_valid` drops for exactly one cycle and returns on the next edge.
- **Wrap-around:** pointers roll from DEPTH-1 to 0 with no gap. `full`/`empty` are derived from `count` only.
- **Full-side flags:** with `count == DEPTH` and a pop, `full` deasserts on the next cycle; a push can be accepted then.

## Test plan
- **Reset and single entry:** release reset, push `0xA5` at edge 1 → `m_valid` = 1 after edge 2 with `m_data` = `0xA5`. Then pop → `empty` = 1, `m_valid` = 0.
- **Fill, drain, overflow attempt:**
  - With DEPTH=16 and `m_ready` = 0, push 0x00..0x0F → `full` = 1, `count` = 16, `s_ready` = 0.
  - Hold `s_valid` = 1 with data `0xFF` → no RAM write.
  - Drain → output sequence 0x00..0x0F exactly.
- **Streaming with pointer wrap:**
  - Keep `s_valid` = `m_ready` = 1 and push 40 incrementing values → output order is preserved across pointer wrap.
  - Once primed, `m_valid` stays continuously high while `count >= 2`.
- **Stall stability:** with `count == 3`, `m_ready` = 0 for 5 cycles → `m_data` is constant and equal to the head entry, and `ram_addr_b` does not change.
- **Bubble case:** with `count == 1`, push `0x11` and pop in the same cycle → `m_valid` = 0 for one cycle, then 1 with `m_data` = `0x11`.
- **Flush and async reset:**
  - With `count == 5`, assert `flush` together with `s_valid` → after the edge, `count` = 0, `empty` = 1, and no write occurred.
  - Assert `rst_n` low mid-stream, between edges → outputs return to reset values immediately.
